// File: rtl/kse_pkg.sv
// Shared FSM state type, test-pattern table and golden adder model for key_search_engine.
package kse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        NEXT,
        FIN
    } kse_state_t;

    // Widest operand the golden model handles; callers zero-extend into it
    localparam int KSE_MAXW         = 16;
    localparam int KSE_NUM_PATTERNS = 8;

    // Each entry is {a[3:0], b[3:0]}; the ROM truncates or zero-extends to W
    localparam logic [7:0] KSE_PATTERNS [KSE_NUM_PATTERNS] = '{
        8'h35, 8'hF1, 8'hA6, 8'h00, 8'h79, 8'hCC, 8'h1E, 8'h88
    };

    function automatic logic [KSE_MAXW:0] golden_sum(input logic [KSE_MAXW-1:0] a,
                                                     input logic [KSE_MAXW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/kse_pattern_rom.sv
// Combinational lookup of one operand pair from the shared test-pattern table.
module kse_pattern_rom
    import kse_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2:0]   pat,
    output logic [W-1:0] a,
    output logic [W-1:0] b
);

    logic [7:0] entry;

    always_comb begin
        entry = KSE_PATTERNS[pat];
        a     = W'(entry[7:4]);
        b     = W'(entry[3:0]);
    end

endmodule

// File: rtl/key_search_engine.sv
// Oracle-guided key sweep against an external key-locked adder.
// Optional KSE_MATCH_COUNT_EN: sweep all keys and count passing ones on match_cnt.
module key_search_engine
    import kse_pkg::*;
#(
    parameter int W    = 4,
    parameter int KW   = 4,
    parameter int NPAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [W-1:0]  dut_a,
    output logic [W-1:0]  dut_b,
    output logic [KW-1:0] dut_key,
    input  logic [W:0]    dut_sum,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [KW-1:0] key_out,
    output logic [KW:0]   tries
`ifdef KSE_MATCH_COUNT_EN
    ,
    output logic [KW:0]   match_cnt
`endif
);

    kse_state_t    state_q, state_d;
    logic [KW-1:0] cand;
    logic [2:0]    pat;
    logic          hit;
    logic [W-1:0]  rom_a, rom_b;
    logic          sum_ok, last_pat, last_cand;

    kse_pattern_rom #(.W(W)) u_rom (
        .pat (pat),
        .a   (rom_a),
        .b   (rom_b)
    );

    // The adder's inputs were registered in APPLY, so dut_sum is settled during SAMPLE
    assign sum_ok    = ((KSE_MAXW+1)'(dut_sum) == golden_sum(KSE_MAXW'(dut_a), KSE_MAXW'(dut_b)));
    assign last_pat  = (pat == 3'(NPAT - 1));
    assign last_cand = (cand == {KW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = APPLY;
            APPLY:  state_d = SAMPLE;
            SAMPLE: begin
                if (!sum_ok)        state_d = NEXT;
                else if (!last_pat) state_d = APPLY;
`ifdef KSE_MATCH_COUNT_EN
                else                state_d = NEXT;
`else
                else                state_d = FIN;
`endif
            end
            NEXT:   state_d = last_cand ? FIN : APPLY;
            FIN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath; hit carries the pass result so done and found rise together in FIN
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_a   <= '0;
            dut_b   <= '0;
            dut_key <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            found   <= 1'b0;
            key_out <= '0;
            tries   <= '0;
            cand    <= '0;
            pat     <= '0;
            hit     <= 1'b0;
`ifdef KSE_MATCH_COUNT_EN
            match_cnt <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        found   <= 1'b0;
                        key_out <= '0;
                        tries   <= '0;
                        cand    <= '0;
                        pat     <= '0;
                        hit     <= 1'b0;
`ifdef KSE_MATCH_COUNT_EN
                        match_cnt <= '0;
`endif
                    end
                end
                APPLY: begin
                    dut_a   <= rom_a;
                    dut_b   <= rom_b;
                    dut_key <= cand;
                end
                SAMPLE: begin
                    if (sum_ok) begin
                        if (!last_pat) begin
                            pat <= pat + 3'd1;
                        end else begin
`ifdef KSE_MATCH_COUNT_EN
                            if (!hit) key_out <= cand;
                            match_cnt <= match_cnt + 1'b1;
`else
                            key_out <= cand;
                            tries   <= tries + 1'b1;
`endif
                            hit <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    tries <= tries + 1'b1;
                    if (!last_cand) begin
                        cand <= cand + 1'b1;
                        pat  <= '0;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    found <= hit;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_engine.sv
// Randomized self-checking bench for key_search_engine with a behavioural locked-adder model.
module tb_key_search_engine;

    localparam int W    = 4;
    localparam int KW   = 4;
    localparam int NPAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  dut_a, dut_b;
    logic [KW-1:0] dut_key;
    logic [W:0]    dut_sum;
    logic          busy, done, found;
    logic [KW-1:0] key_out;
    logic [KW:0]   tries;
`ifdef KSE_MATCH_COUNT_EN
    logic [KW:0]   match_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Keys the locked adder accepts, and per rejected key the pattern index where it first misbehaves
    logic [15:0] accept;
    int          fail_pat [16];

    logic [W-1:0] tb_pat_a [4] = '{4'd3, 4'd15, 4'd10, 4'd0};
    logic [W-1:0] tb_pat_b [4] = '{4'd5, 4'd1,  4'd6,  4'd0};

    key_search_engine #(.W(W), .KW(KW), .NPAT(NPAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dut_a   (dut_a),
        .dut_b   (dut_b),
        .dut_key (dut_key),
        .dut_sum (dut_sum),
        .busy    (busy),
        .done    (done),
        .found   (found),
        .key_out (key_out),
        .tries   (tries)
`ifdef KSE_MATCH_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [W:0] true_sum;
    int         pidx;

    always_comb begin
        true_sum = {1'b0, dut_a} + {1'b0, dut_b};
        pidx     = -1;
        for (int i = 0; i < 4; i++)
            if (dut_a == tb_pat_a[i] && dut_b == tb_pat_b[i]) pidx = i;
        if (accept[dut_key])                  dut_sum = true_sum;
        else if (pidx == fail_pat[dut_key])   dut_sum = true_sum + 5'd1;
        else                                  dut_sum = true_sum;
    end

    // Expected sweep outcome from the accept set and each key's failing pattern
    task automatic model(output bit ef, output logic [KW-1:0] ek, output int et,
                         output int ec, output int em);
        ef = 0; ek = '0; et = 0; ec = 2; em = 0;
        for (int c = 0; c < 16; c++) begin
`ifndef KSE_MATCH_COUNT_EN
            if (ef) break;
`endif
            et++;
            if (accept[c]) begin
                if (!ef) ek = KW'(c);
                ef = 1;
                em++;
`ifdef KSE_MATCH_COUNT_EN
                ec += 2 * NPAT + 1;
`else
                ec += 2 * NPAT;
`endif
            end else begin
                ec += 2 * (fail_pat[c] + 1) + 1;
            end
        end
    endtask

    task automatic applyStimulus(input int pulse_at, output int cycles);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_rise: got %b want 1", busy); end
        cycles = 1;
        while (done !== 1'b1 && cycles < 400) begin
            if (cycles == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_timeout: got %b want 1 after %0d cycles", done, cycles); end
    endtask

    task automatic randomize_fail_pats();
        for (int i = 0; i < 16; i++) fail_pat[i] = int'($urandom_range(0, NPAT - 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dut_a, dut_b, dut_key, busy, done, found, key_out, tries} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got a=%0d b=%0d key=%0d busy=%b done=%b found=%b key_out=%0d tries=%0d want all 0",
                     dut_a, dut_b, dut_key, busy, done, found, key_out, tries);
        end
`ifdef KSE_MATCH_COUNT_EN
        checks++;
        if (match_cnt !== '0) begin errors++; $display("[TB] FAIL reset_match_cnt: got %0d want 0", match_cnt); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_known_key();
        bit ef; logic [KW-1:0] ek; int et, ec, em, cyc;
        accept = 16'h0400;
        randomize_fail_pats();
        model(ef, ek, et, ec, em);
        applyStimulus(0, cyc);
        checks++; if (found !== ef)         begin errors++; $display("[TB] FAIL known_found: got %b want %b", found, ef); end
        checks++; if (key_out !== ek)       begin errors++; $display("[TB] FAIL known_key: got %0d want %0d", key_out, ek); end
        checks++; if (tries !== (KW+1)'(et)) begin errors++; $display("[TB] FAIL known_tries: got %0d want %0d", tries, et); end
        checks++; if (cyc != ec)            begin errors++; $display("[TB] FAIL known_cycles: got %0d want %0d", cyc, ec); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL known_busy_low: got %b want 0", busy); end
    endtask

    task automatic test_key_zero();
        bit ef; logic [KW-1:0] ek; int et, ec, em, cyc;
        accept = 16'h0001;
        randomize_fail_pats();
        model(ef, ek, et, ec, em);
        applyStimulus(0, cyc);
        checks++; if (found !== 1'b1)       begin errors++; $display("[TB] FAIL zero_found: got %b want 1", found); end
        checks++; if (key_out !== 4'd0)     begin errors++; $display("[TB] FAIL zero_key: got %0d want 0", key_out); end
        checks++; if (tries !== (KW+1)'(et)) begin errors++; $display("[TB] FAIL zero_tries: got %0d want %0d", tries, et); end
        checks++; if (cyc != ec)            begin errors++; $display("[TB] FAIL zero_cycles: got %0d want %0d", cyc, ec); end
    endtask

    task automatic test_no_key();
        int cyc;
        accept = 16'h0000;
        for (int i = 0; i < 16; i++) fail_pat[i] = 0;
        applyStimulus(0, cyc);
        checks++; if (found !== 1'b0)       begin errors++; $display("[TB] FAIL nokey_found: got %b want 0", found); end
        checks++; if (key_out !== 4'd0)     begin errors++; $display("[TB] FAIL nokey_key: got %0d want 0", key_out); end
        checks++; if (tries !== 5'd16)      begin errors++; $display("[TB] FAIL nokey_tries: got %0d want 16", tries); end
        checks++; if (cyc != 16 * 3 + 2)    begin errors++; $display("[TB] FAIL nokey_cycles: got %0d want %0d", cyc, 16 * 3 + 2); end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        accept = 16'h0400;
        randomize_fail_pats();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, dut_key} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got busy=%b done=%b key=%0d want 0 0 0", busy, done, dut_key);
        end
        applyStimulus(0, cyc);
        checks++; if (found !== 1'b1)   begin errors++; $display("[TB] FAIL midreset_found: got %b want 1", found); end
        checks++; if (key_out !== 4'd10) begin errors++; $display("[TB] FAIL midreset_key: got %0d want 10", key_out); end
    endtask

    task automatic test_back_to_back();
        bit ef; logic [KW-1:0] ek; int et, ec, em, cyc;
        accept = 16'h0400;
        randomize_fail_pats();
        model(ef, ek, et, ec, em);
        applyStimulus(5, cyc);
        checks++; if (cyc != ec)            begin errors++; $display("[TB] FAIL busystart_cycles: got %0d want %0d", cyc, ec); end
        checks++; if (key_out !== ek)       begin errors++; $display("[TB] FAIL busystart_key: got %0d want %0d", key_out, ek); end
        @(posedge clk); #1;
        applyStimulus(0, cyc);
        checks++; if (cyc != ec)            begin errors++; $display("[TB] FAIL restart_cycles: got %0d want %0d", cyc, ec); end
        checks++; if (found !== ef)         begin errors++; $display("[TB] FAIL restart_found: got %b want %b", found, ef); end
        checks++; if (key_out !== ek)       begin errors++; $display("[TB] FAIL restart_key: got %0d want %0d", key_out, ek); end
        checks++; if (tries !== (KW+1)'(et)) begin errors++; $display("[TB] FAIL restart_tries: got %0d want %0d", tries, et); end
    endtask

    task automatic test_random();
        bit ef; logic [KW-1:0] ek; int et, ec, em, cyc;
        for (int n = 0; n < 6; n++) begin
            accept = 16'($urandom) & 16'($urandom) & 16'($urandom);
            randomize_fail_pats();
            model(ef, ek, et, ec, em);
            applyStimulus(0, cyc);
            checks++; if (found !== ef)         begin errors++; $display("[TB] FAIL rand%0d_found: got %b want %b", n, found, ef); end
            checks++; if (key_out !== ek)       begin errors++; $display("[TB] FAIL rand%0d_key: got %0d want %0d", n, key_out, ek); end
            checks++; if (tries !== (KW+1)'(et)) begin errors++; $display("[TB] FAIL rand%0d_tries: got %0d want %0d", n, tries, et); end
            checks++; if (cyc != ec)            begin errors++; $display("[TB] FAIL rand%0d_cycles: got %0d want %0d", n, cyc, ec); end
`ifdef KSE_MATCH_COUNT_EN
            checks++; if (match_cnt !== (KW+1)'(em)) begin errors++; $display("[TB] FAIL rand%0d_match_cnt: got %0d want %0d", n, match_cnt, em); end
`endif
            @(posedge clk); #1;
        end
    endtask

`ifdef KSE_MATCH_COUNT_EN
    task automatic test_match_count();
        bit ef; logic [KW-1:0] ek; int et, ec, em, cyc;
        accept = 16'h0408;
        randomize_fail_pats();
        model(ef, ek, et, ec, em);
        applyStimulus(0, cyc);
        checks++; if (found !== 1'b1)      begin errors++; $display("[TB] FAIL mc_found: got %b want 1", found); end
        checks++; if (key_out !== 4'd3)    begin errors++; $display("[TB] FAIL mc_key: got %0d want 3", key_out); end
        checks++; if (match_cnt !== 5'd2)  begin errors++; $display("[TB] FAIL mc_count: got %0d want 2", match_cnt); end
        checks++; if (tries !== 5'd16)     begin errors++; $display("[TB] FAIL mc_tries: got %0d want 16", tries); end
        checks++; if (cyc != ec)           begin errors++; $display("[TB] FAIL mc_cycles: got %0d want %0d", cyc, ec); end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        accept = 16'h0000;
        for (int i = 0; i < 16; i++) fail_pat[i] = 0;
        test_reset();
        test_known_key();
        test_key_zero();
        test_no_key();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
`ifdef KSE_MATCH_COUNT_EN
        test_match_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
